// File: rtl/bsg_dataflow_pkg.sv
// Shared dataflow definitions: credit counter sizing and error-flag encoding.
package bsg_dataflow_pkg;

  // Error flag encoding; overflow is sticky until reset.
  typedef enum logic {
    ErrNone     = 1'b0,
    ErrOverflow = 1'b1
  } dataflow_err_e;

  // Bits needed to hold a credit count in [0, max_val].
  function automatic int unsigned credit_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/bsg_credit_counter_up_down_sat.sv
// Saturating credit counter: up by up_val_p, down by one, sticky overflow flag.
module bsg_credit_counter_up_down_sat
  import bsg_dataflow_pkg::*;
#(
  parameter int unsigned max_val_p  = 8,
  parameter int unsigned init_val_p = 8,
  parameter int unsigned up_val_p   = 1,
  localparam int unsigned width_lp  = credit_width(max_val_p)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                up_i,
  input  logic                down_i,
  output logic [width_lp-1:0] count_o,
  output logic                overflow_o
);

  localparam logic [width_lp:0]   max_wide_lp = (width_lp + 1)'(max_val_p);
  localparam logic [width_lp:0]   up_wide_lp  = (width_lp + 1)'(up_val_p);
  localparam logic [width_lp-1:0] init_lp     = width_lp'(init_val_p);

  logic [width_lp-1:0] count_q, count_d;
  dataflow_err_e       err_q, err_d;
  logic                down_ok;
  logic [width_lp:0]   sum;

  // Next count computed one bit wider so an overshoot past max is visible.
  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    // Never decrement an empty counter.
    down_ok = down_i & (count_q != '0);
    sum     = {1'b0, count_q} + (up_i ? up_wide_lp : '0) - {{width_lp{1'b0}}, down_ok};
    if (sum > max_wide_lp) begin
      count_d = max_wide_lp[width_lp-1:0];
      err_d   = ErrOverflow;
    end else begin
      count_d = sum[width_lp-1:0];
    end
  end

  // Count and sticky error state.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= init_lp;
      err_q   <= ErrNone;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign count_o    = count_q;
  assign overflow_o = (err_q == ErrOverflow);

endmodule

// File: rtl/bsg_ready_to_credit_flow_converter.sv
// Converts an upstream ready/valid stream into a credit-based downstream stream.
module bsg_ready_to_credit_flow_converter
  import bsg_dataflow_pkg::*;
#(
  parameter int unsigned width_p          = 32,
  parameter int unsigned credit_initial_p = 8,
  parameter int unsigned credit_max_val_p = 8,
  parameter int unsigned decimation_p     = 1,
  localparam int unsigned credit_width_lp = credit_width(credit_max_val_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       v_i,
  input  logic [width_p-1:0]         data_i,
  output logic                       ready_o,
  output logic                       v_o,
  output logic [width_p-1:0]         data_o,
  input  logic                       ready_i,
  input  logic                       credit_i,
  output logic [credit_width_lp-1:0] credits_o,
  output logic                       overflow_o
);

  if (credit_max_val_p < credit_initial_p) begin : g_bad_initial
    $error("credit_max_val_p must be >= credit_initial_p");
  end
  if (decimation_p < 1 || decimation_p > credit_max_val_p) begin : g_bad_decimation
    $error("decimation_p must be in [1, credit_max_val_p]");
  end

  logic [1:0] rst_sync_q;
  logic       rst_sync_n;
  logic       send;

  // Assert asynchronously, release two edges after reset_n_i rises.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_sync_n = rst_sync_q[1];

  // Handshake is purely combinational; payload passes straight through.
  always_comb begin
    ready_o = rst_sync_n & (credits_o != '0) & ready_i;
    send    = v_i & ready_o;
    v_o     = send;
    data_o  = data_i;
  end

  bsg_credit_counter_up_down_sat #(
    .max_val_p  (credit_max_val_p),
    .init_val_p (credit_initial_p),
    .up_val_p   (decimation_p)
  ) u_counter (
    .clk_i      (clk_i),
    .reset_n_i  (rst_sync_n),
    .up_i       (credit_i),
    .down_i     (send),
    .count_o    (credits_o),
    .overflow_o (overflow_o)
  );

endmodule
